hc_enc_stream: RTL and testbench
================================

# hc_enc_stream

Streaming Hamming(7,4) encoder, the transmit-side counterpart of `hc_decode`. It accepts bytes over a valid/ready handshake and splits each into two nibbles, low nibble first. It emits one registered 7-bit codeword per nibble on a downstream valid/ready handshake, with an optional 8th overall-parity bit for SECDED. A per-byte single-bit error-injection field lets benches exercise the decoder's correction path.

## Interface
- `EXT_PARITY`, default 0: 1 appends an overall parity bit, so `CW_W = 7 + EXT_PARITY`.
- `CNT_W`, default 16: width of the codeword transfer counter.
- `i_clk` in 1: clock. Everything is rising-edge.
- `i_rst_n` in 1: synchronous active-low reset, sampled on `i_clk`.
- `i_data` in [8:1]: input byte. Low nibble is [4:1], high nibble is [8:5].
- `i_inj_pos` in [3:1]: error injection position, sampled with the byte. 0 means none; 1-7 flips that codeword position in the low-nibble codeword only.
- `i_valid` in 1: input byte valid.
- `o_ready` out 1: block can accept a byte this cycle.
- `o_enc_data` out [CW_W:1]: codeword. Bit `CW_W` is overall parity when `EXT_PARITY` = 1.
- `o_valid` out 1: codeword valid.
- `i_ready` in 1: downstream accepts the codeword.
- `o_cw_cnt` out [CNT_W:1]: count of completed codeword transfers.

## Operation
- Encoding of nibble n, where n[1] is the LSB:
  - Data: pos3 = n[1], pos5 = n[2], pos6 = n[3], pos7 = n[4].
  - Parity: pos1 = pos3^pos5^pos7, pos2 = pos3^pos6^pos7, pos4 = pos5^pos6^pos7.
  - `o_enc_data[k]` = pos k.
- Overall parity (`EXT_PARITY` = 1): bit 8 = XOR of pos1..pos7, computed before injection, so an injected error yields a SECDED single-error signature.
- Injection: when `i_inj_pos` = p ≠ 0, the low codeword has bit p inverted. The high codeword is never injected.
- States:
  - IDLE: no codeword held.
  - LO: presenting the low-nibble codeword.
  - HI: presenting the high-nibble codeword.
- Transitions:
  - IDLE → LO on accept (`i_valid` && `o_ready`).
  - LO → HI on `i_ready`.
  - HI → LO on `i_ready` with a simultaneous accept.
  - HI → IDLE on `i_ready` without an accept.
  - Any other cycle holds state.
- `o_ready` = `i_rst_n` && (state == IDLE || (state == HI && `i_ready`)). This is a deliberate combinational path from `i_ready` to `o_ready`.
- The byte and injection position are captured in a holding register on accept. The high nibble comes from that register, not from `i_data`.
- `o_cw_cnt` increments by 1 on every `o_valid` && `i_ready` cycle and wraps from all-ones to 0.
- Inputs are don't-care when `i_valid` = 0. An `i_valid` without `o_ready` is ignored, with no capture.

## Timing
- Reset (`i_rst_n` = 0 at an edge): state = IDLE, `o_valid` = 0, `o_enc_data` = 0, `o_cw_cnt` = 0, holding register = 0. `o_ready` = 0 while `i_rst_n` is low.
- Reset mid-operation drops any held byte without emitting its remaining codewords.
- Latency: a byte accepted at edge N gives `o_valid` = 1 and the low codeword at `o_enc_data` after edge N.
  - The high codeword appears after the edge where the low codeword is taken.
- Throughput: with `i_ready` held high, one byte per 2 cycles, and `o_valid` stays high continuously.
- Stability: while `o_valid` = 1 and `i_ready` = 0, `o_enc_data` and `o_valid` hold stable.
  - Back-pressure of any length is legal.
- `o_valid` never drops without a transfer except on reset.
- Outputs are registered; `o_ready` is the only combinational output.

## Test plan
- Reset: hold `i_rst_n` = 0 for 3 cycles with `i_valid` = 1 → `o_ready` = 0, `o_valid` = 0, `o_enc_data` = 0, `o_cw_cnt` = 0. The first accept happens only after release.
- Basic encode: byte 0xA5, `i_inj_pos` = 0, `i_ready` = 1 → codeword 7'b0101101, then 7'b1010010 on consecutive cycles. `o_cw_cnt` = 2.
  - With `EXT_PARITY` = 1, the codewords are 8'b00101101 and 8'b11010010.
- Extremes: byte 0x00 → 7'b0000000 twice. Byte 0xFF → 7'b1111111 twice, and with `EXT_PARITY` = 1, 8'b11111111 twice.
- Injection: byte 0xA5 with `i_inj_pos` = 3 → low codeword 7'b0101001, high codeword unaltered at 7'b1010010.
  - Feeding each codeword to `hc_decode` returns nibbles 4'b0101 and 4'b1010, with the error flag set only on the first.
- Back-pressure: byte 0x3C, `i_ready` = 0 for 5 cycles, then 1 → low codeword held stable for all 5 cycles. `o_ready` = 0 throughout, and a second byte offered meanwhile is not captured.
- Streaming and wrap: 8 back-to-back bytes with `i_ready` = 1 and `CNT_W` = 4 → 16 contiguous codewords in low/high order with no bubble. `o_cw_cnt` wraps from 15 to 0 on the 16th transfer.

Source files
------------

// File: rtl/hc_enc_stream.sv
// rtl/hc_enc_stream.sv - streaming Hamming(7,4) byte encoder, low nibble first, optional SECDED parity
module hc_enc_stream #(
    parameter int EXT_PARITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [8:1]            i_data,
    input  logic [3:1]            i_inj_pos,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [7+EXT_PARITY:1] o_enc_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CNT_W:1]        o_cw_cnt
);

    localparam int CW_W = 7 + EXT_PARITY;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:1]      r_hold_hi;
    logic [CW_W:1]   r_enc_data;
    logic            r_valid;
    logic [CNT_W:1]  r_cnt;

    logic            w_accept;
    logic            w_load_hi;
    logic            w_drop;
    logic [7:1]      w_lo_base;
    logic [7:1]      w_hi_base;
    logic [7:1]      w_inj_mask;
    logic [CW_W:1]   w_lo_cw;
    logic [CW_W:1]   w_hi_cw;

    // Codeword position k maps to bit k; data sits at 3,5,6,7.
    function automatic logic [7:1] f_ham(input logic [4:1] n);
        logic p1, p2, p4;
        p1 = n[1] ^ n[2] ^ n[4];
        p2 = n[1] ^ n[3] ^ n[4];
        p4 = n[2] ^ n[3] ^ n[4];
        return {n[4], n[3], n[2], p4, n[1], p2, p1};
    endfunction

    assign w_lo_base  = f_ham(i_data[4:1]);
    assign w_hi_base  = f_ham(r_hold_hi);
    assign w_inj_mask = (i_inj_pos == 3'd0) ? 7'd0 : (7'd1 << (i_inj_pos - 3'd1));

    // Overall parity covers the clean codeword so an injected flip reads as a single error.
    if (EXT_PARITY != 0) begin : g_par
        assign w_lo_cw = {^w_lo_base, w_lo_base ^ w_inj_mask};
        assign w_hi_cw = {^w_hi_base, w_hi_base};
    end else begin : g_nopar
        assign w_lo_cw = w_lo_base ^ w_inj_mask;
        assign w_hi_cw = w_hi_base;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_LO;
            S_LO:   if (i_ready)  w_state_nxt = S_HI;
            S_HI:   if (i_ready)  w_state_nxt = w_accept ? S_LO : S_IDLE;
            default:              w_state_nxt = S_IDLE;
        endcase
    end

    // o_ready deliberately passes i_ready through combinationally in HI.
    always_comb begin
        o_ready   = i_rst_n && ((r_state == S_IDLE) || ((r_state == S_HI) && i_ready));
        w_accept  = i_valid && o_ready;
        w_load_hi = (r_state == S_LO) && i_ready;
        w_drop    = (r_state == S_HI) && i_ready && !w_accept;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_hi  <= '0;
            r_enc_data <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_hold_hi  <= i_data[8:5];
                r_enc_data <= w_lo_cw;
                r_valid    <= 1'b1;
            end else if (w_load_hi) begin
                r_enc_data <= w_hi_cw;
            end else if (w_drop) begin
                r_valid    <= 1'b0;
            end
            if (r_valid && i_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_enc_data = r_enc_data;
    assign o_valid    = r_valid;
    assign o_cw_cnt   = r_cnt;

endmodule

// File: tb/tb_hc_enc_stream.sv
// tb/tb_hc_enc_stream.sv - directed bench for hc_enc_stream, plain and SECDED instances side by side
module tb_hc_enc_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:1] data = '0;
    logic [3:1] inj = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy_a, vld_a, rdy_b, vld_b;
    logic [7:1] enc_a;
    logic [8:1] enc_b;
    logic [4:1] cnt_a, cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hc_enc_stream #(.EXT_PARITY(0), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_inj_pos(inj), .i_valid(in_valid),
        .o_ready(rdy_a), .o_enc_data(enc_a), .o_valid(vld_a), .i_ready(out_ready), .o_cw_cnt(cnt_a)
    );

    hc_enc_stream #(.EXT_PARITY(1), .CNT_W(4)) dut_p (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_inj_pos(inj), .i_valid(in_valid),
        .o_ready(rdy_b), .o_enc_data(enc_b), .o_valid(vld_b), .i_ready(out_ready), .o_cw_cnt(cnt_b)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ref_enc(input logic [3:0] n);
        logic p1, p2, p4;
        p1 = n[0] ^ n[1] ^ n[3];
        p2 = n[0] ^ n[2] ^ n[3];
        p4 = n[1] ^ n[2] ^ n[3];
        return {n[3], n[2], n[1], p4, n[0], p2, p1};
    endfunction

    // Returns {error_flag, corrected nibble}.
    function automatic logic [4:0] ref_dec(input logic [6:0] cw);
        logic [6:0] c;
        logic [2:0] s;
        c = cw;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
        return {s != 3'd0, c[6], c[5], c[4], c[2]};
    endfunction

    task automatic check_both(input string tag, input logic [6:0] e7, input logic [7:0] e8, input logic ev);
        check_vec({tag, "_valid"}, {31'd0, vld_a}, {31'd0, ev});
        check_vec({tag, "_cw"}, {25'd0, enc_a}, {25'd0, e7});
        check_vec({tag, "_valid_p"}, {31'd0, vld_b}, {31'd0, ev});
        check_vec({tag, "_cw_p"}, {24'd0, enc_b}, {24'd0, e8});
    endtask

    task automatic xfer_byte(input string tag, input logic [7:0] b, input logic [2:0] p,
                             input logic [6:0] lo7, input logic [7:0] lo8,
                             input logic [6:0] hi7, input logic [7:0] hi8);
        data = b; inj = p; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_vec({tag, "_rdy"}, {31'd0, rdy_a}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_both({tag, "_lo"}, lo7, lo8, 1'b1);
        tick();
        check_both({tag, "_hi"}, hi7, hi8, 1'b1);
        tick();
        check_vec({tag, "_idle"}, {31'd0, vld_a}, 32'd0);
    endtask

    initial begin
        logic [7:0] bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        logic [4:0] d;

        rst_n = 1'b0; in_valid = 1'b1; data = 8'h5A; out_ready = 1'b1;
        repeat (3) tick();
        check_vec("rst_ready", {30'd0, rdy_a, rdy_b}, 32'd0);
        check_both("rst", 7'd0, 8'd0, 1'b0);
        check_vec("rst_cnt", {24'd0, cnt_a, cnt_b}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check_vec("post_rst_valid", {31'd0, vld_a}, 32'd0);

        xfer_byte("a5", 8'hA5, 3'd0, 7'b0101101, 8'b00101101, 7'b1010010, 8'b11010010);
        check_vec("a5_cnt", {28'd0, cnt_a}, 32'd2);
        check_vec("a5_cnt_p", {28'd0, cnt_b}, 32'd2);

        xfer_byte("x00", 8'h00, 3'd0, 7'b0000000, 8'b00000000, 7'b0000000, 8'b00000000);
        xfer_byte("xff", 8'hFF, 3'd0, 7'b1111111, 8'b11111111, 7'b1111111, 8'b11111111);

        // Injection: decode each codeword as it is presented.
        data = 8'hA5; inj = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; inj = 3'd0;
        check_both("inj_lo", 7'b0101001, 8'b00101001, 1'b1);
        d = ref_dec(enc_a);
        check_vec("inj_lo_dec", {27'd0, d}, {27'd0, 5'b1_0101});
        tick();
        check_both("inj_hi", 7'b1010010, 8'b11010010, 1'b1);
        d = ref_dec(enc_a);
        check_vec("inj_hi_dec", {27'd0, d}, {27'd0, 5'b0_1010});
        tick();
        check_vec("inj_cnt", {28'd0, cnt_a}, 32'd8);

        // Back-pressure with a second byte offered during the stall.
        data = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_vec("bp_rdy", {30'd0, rdy_a, rdy_b}, 32'd0);
            check_both("bp_hold", 7'b1100001, 8'b11100001, 1'b1);
            check_vec("bp_cnt", {28'd0, cnt_a}, 32'd8);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_both("bp_hi", 7'b0011110, 8'b00011110, 1'b1);
        tick();
        check_vec("bp_idle", {31'd0, vld_a}, 32'd0);
        check_vec("bp_cnt_end", {28'd0, cnt_a}, 32'd10);

        // Reset then 8 back-to-back bytes: 16 codewords, counter wraps to 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_vec("str_cnt0", {28'd0, cnt_a}, 32'd0);
        data = bytes[0]; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check_both("str_lo", ref_enc(bytes[k][3:0]), {^ref_enc(bytes[k][3:0]), ref_enc(bytes[k][3:0])}, 1'b1);
            check_vec("str_lo_cnt", {28'd0, cnt_a}, (2 * k) % 16);
            tick();
            check_both("str_hi", ref_enc(bytes[k][7:4]), {^ref_enc(bytes[k][7:4]), ref_enc(bytes[k][7:4])}, 1'b1);
            check_vec("str_hi_cnt", {28'd0, cnt_a}, (2 * k + 1) % 16);
            if (k < 7) data = bytes[k + 1];
            else       in_valid = 1'b0;
            #1;
            check_vec("str_rdy", {31'd0, rdy_a}, 32'd1);
            tick();
        end
        check_vec("str_end_valid", {31'd0, vld_a}, 32'd0);
        check_vec("str_wrap", {28'd0, cnt_a}, 32'd0);
        check_vec("str_wrap_p", {28'd0, cnt_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
